mem_arbiter: RTL

- Sits directly upstream of the variable-latency ram and is the ram's only master.
- Arbitrates between instruction-fetch (i-side) and data (d-side) requesters, drives the cpu_ram_if master signals, and returns per-requester wait/load.
- Holds each granted transaction stable until the ram reports ACCESS.
- Detects ram ERROR states and stuck transactions.

---
 rtl/mem_arbiter.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Arbitrates the instruction-fetch and data requesters onto the single ram master port.
// The grant is held until the ram reports ACCESS, ERROR, a watchdog expiry, or the requester withdraws.
package mem_arbiter_pkg;
  typedef enum logic [1:0] {
    FREE   = 2'b00,
    BUSY   = 2'b01,
    ACCESS = 2'b10,
    ERROR  = 2'b11
  } ramstate_t;
endpackage

module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64,
  parameter logic [31:0] BAD     = 32'hBAD1BAD1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  ramstate_t   ramstate,
  output logic        err,
  output logic [1:0]  err_code
);

  localparam int unsigned WDOG_W      = $clog2(TIMEOUT) + 1;
  localparam logic [1:0]  ERR_RAM     = 2'b01;
  localparam logic [1:0]  ERR_TIMEOUT = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    IGNT,
    DGNT
  } state_t;

  state_t              state;
  logic                last_d;
  logic [WDOG_W-1:0]   wdog;

  logic                granted_c;
  logic                access_c;
  logic                ram_fault_c;
  logic                req_held_c;
  logic                timeout_c;
  logic                d_pending_c;
  logic                d_first_c;

  // Transaction status decode from the current grant and ram state.
  always_comb begin
    granted_c   = (state != IDLE);
    access_c    = granted_c && (ramstate == ACCESS);
    ram_fault_c = granted_c && (ramstate == ERROR);
    req_held_c  = (state == IGNT) ? iREN : (dREN | dWEN);
    timeout_c   = granted_c && (ramstate != ACCESS) && (wdog == WDOG_W'(TIMEOUT - 1));
    d_pending_c = dREN | dWEN;
    d_first_c   = d_pending_c && (!iREN || !last_d);
  end

  // Completion is reported in the ACCESS cycle itself, so wait/load are combinational.
  always_comb begin
    iwait = 1'b1;
    iload = BAD;
    dwait = 1'b1;
    dload = BAD;
    if (access_c && (state == IGNT)) begin
      iwait = 1'b0;
      iload = ramload;
    end
    if (access_c && (state == DGNT)) begin
      dwait = 1'b0;
      if (ramREN) begin
        dload = ramload;
      end
    end
  end

  // Grant FSM; ram master signals are registered alongside the state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      last_d   <= 1'b0;
      wdog     <= '0;
      err      <= 1'b0;
      err_code <= 2'b00;
      ramREN   <= 1'b0;
      ramWEN   <= 1'b0;
      ramaddr  <= '0;
      ramstore <= '0;
    end else begin
      state    <= IDLE;
      wdog     <= '0;
      ramREN   <= 1'b0;
      ramWEN   <= 1'b0;
      ramaddr  <= '0;
      ramstore <= '0;
      case (state)
        IDLE: begin
          if (d_first_c) begin
            state    <= DGNT;
            ramREN   <= dREN;
            ramWEN   <= dWEN;
            ramaddr  <= daddr;
            ramstore <= dstore;
          end else if (iREN) begin
            state   <= IGNT;
            ramREN  <= 1'b1;
            ramaddr <= iaddr;
          end
        end
        IGNT, DGNT: begin
          if (ram_fault_c) begin
            err <= 1'b1;
            if (!err) begin
              err_code <= ERR_RAM;
            end
          end else if (access_c) begin
            last_d <= (state == DGNT);
          end else if (req_held_c && timeout_c) begin
            err <= 1'b1;
            if (!err) begin
              err_code <= ERR_TIMEOUT;
            end
          end else if (req_held_c) begin
            // Stay granted; address/data changes pass through and restart the ram count.
            state <= state;
            wdog  <= (wdog == {WDOG_W{1'b1}}) ? wdog : wdog + WDOG_W'(1);
            if (state == IGNT) begin
              ramREN  <= 1'b1;
              ramaddr <= iaddr;
            end else begin
              ramREN   <= dREN;
              ramWEN   <= dWEN;
              ramaddr  <= daddr;
              ramstore <= dstore;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
